// File: rtl/axi4_lite_rgb_pwm.sv
// AXI4-Lite register block driving six 8-bit PWM channels for the two on-board RGB LEDs.
// Duty values are shadowed at the phase wrap so a period never shows a half-updated duty.
module axi4_lite_rgb_pwm #(
    parameter int A = 16,
    parameter int N = 4
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [A-1:0]   awaddr,
    input  logic           awvalid,
    output logic           awready,
    input  logic [8*N-1:0] wdata,
    input  logic [N-1:0]   wstrb,
    input  logic           wvalid,
    output logic           wready,
    output logic [1:0]     bresp,
    output logic           bvalid,
    input  logic           bready,
    input  logic [A-1:0]   araddr,
    input  logic           arvalid,
    output logic           arready,
    output logic [8*N-1:0] rdata,
    output logic [1:0]     rresp,
    output logic           rvalid,
    input  logic           rready,
    output logic           HD_GPIO_RGB1_R,
    output logic           HD_GPIO_RGB1_G,
    output logic           HD_GPIO_RGB1_B,
    output logic           HP_GPIO_RGB2_R,
    output logic           HP_GPIO_RGB2_G,
    output logic           HP_GPIO_RGB2_B
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic           ready_en;
    logic           aw_held;
    logic [A-1:0]   aw_addr;
    logic           w_held;
    logic [8*N-1:0] w_data;
    logic [N-1:0]   w_strb;
    logic           ar_stage;

    logic           enable;
    logic [15:0]    prescale;
    logic [23:0]    rgb1;
    logic [23:0]    rgb2;

    logic [15:0]    pre_cnt;
    logic [7:0]     phase;
    logic [23:0]    shadow1;
    logic [23:0]    shadow2;
    logic [5:0]     led;

    logic [31:0]    reg_file [0:7];
    logic [31:0]    wr_old;
    logic [31:0]    wr_val;
    logic           aw_hs;
    logic           w_hs;
    logic           ar_hs;
    logic           commit;
    logic           unused;

    function automatic logic addr_hit(input logic [A-1:0] addr);
        return (addr[A-1:5] == '0) && (addr[4:2] <= 3'd4);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    // ready_en keeps every ready low until the first edge after reset is released
    assign awready = ready_en && !aw_held && !bvalid;
    assign wready  = ready_en && !w_held && !bvalid;
    assign arready = ready_en && !rvalid && !ar_stage;

    assign aw_hs  = awvalid && awready;
    assign w_hs   = wvalid && wready;
    assign ar_hs  = arvalid && arready;
    assign commit = aw_held && w_held;

    always_comb begin
        for (int i = 0; i < 8; i++) reg_file[i] = '0;
        reg_file[0] = {31'b0, enable};
        reg_file[1] = {16'b0, prescale};
        reg_file[2] = {8'b0, rgb1};
        reg_file[3] = {8'b0, rgb2};
        reg_file[4] = {23'b0, enable, phase};
    end

    assign wr_old = reg_file[aw_addr[4:2]];
    assign wr_val = merge(wr_old, w_data, w_strb);
    assign unused = &{1'b0, aw_addr[1:0], araddr[1:0], wr_val[31:24]};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ready_en <= 1'b0;
            aw_held  <= 1'b0;
            aw_addr  <= '0;
            w_held   <= 1'b0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            ready_en <= 1'b1;
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bresp   <= addr_hit(aw_addr) ? RESP_OKAY : RESP_DECERR;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_addr <= awaddr;
                end
                if (w_hs) begin
                    w_held <= 1'b1;
                    w_data <= wdata;
                    w_strb <= wstrb;
                end
            end
            if (bvalid && bready) bvalid <= 1'b0;
            else if (commit)      bvalid <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            enable   <= 1'b0;
            prescale <= 16'h00FF;
            rgb1     <= '0;
            rgb2     <= '0;
        end else if (commit && addr_hit(aw_addr)) begin
            case (aw_addr[4:2])
                3'd0:    enable   <= wr_val[0];
                3'd1:    prescale <= wr_val[15:0];
                3'd2:    rgb1     <= wr_val[23:0];
                3'd3:    rgb2     <= wr_val[23:0];
                default: ;
            endcase
        end
    end

    // Read data is captured at the AR handshake so a same-edge commit is not observed
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ar_stage <= 1'b0;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                ar_stage <= 1'b1;
                rdata    <= addr_hit(araddr) ? reg_file[araddr[4:2]] : '0;
                rresp    <= addr_hit(araddr) ? RESP_OKAY : RESP_DECERR;
            end
            if (ar_stage) begin
                ar_stage <= 1'b0;
                rvalid   <= 1'b1;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            pre_cnt <= '0;
            phase   <= '0;
            shadow1 <= '0;
            shadow2 <= '0;
            led     <= '0;
        end else if (!enable) begin
            pre_cnt <= '0;
            phase   <= '0;
            shadow1 <= rgb1;
            shadow2 <= rgb2;
            led     <= '0;
        end else begin
            led <= {phase < shadow1[23:16], phase < shadow1[15:8], phase < shadow1[7:0],
                    phase < shadow2[23:16], phase < shadow2[15:8], phase < shadow2[7:0]};
            if (pre_cnt >= prescale) begin
                pre_cnt <= '0;
                phase   <= phase + 8'd1;
                if (phase == 8'd255) begin
                    shadow1 <= rgb1;
                    shadow2 <= rgb2;
                end
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
        end
    end

    assign {HD_GPIO_RGB1_R, HD_GPIO_RGB1_G, HD_GPIO_RGB1_B,
            HP_GPIO_RGB2_R, HP_GPIO_RGB2_G, HP_GPIO_RGB2_B} = led;

endmodule

// File: tb/tb_axi4_lite_rgb_pwm.sv
// Directed plus randomized bench for axi4_lite_rgb_pwm against a register-map and duty-count model.
module tb_axi4_lite_rgb_pwm;

    logic        aclk = 1'b0;
    logic        areset;
    logic [15:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        r1_r, r1_g, r1_b, r2_r, r2_g, r2_b;
    logic [5:0]  leds;

    int total = 0;
    int bad = 0;
    int hi[6];
    logic [31:0] mreg[0:3];

    axi4_lite_rgb_pwm #(.A(16), .N(4)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .HD_GPIO_RGB1_R(r1_r), .HD_GPIO_RGB1_G(r1_g), .HD_GPIO_RGB1_B(r1_b),
        .HP_GPIO_RGB2_R(r2_r), .HP_GPIO_RGB2_G(r2_g), .HP_GPIO_RGB2_B(r2_b)
    );

    assign leds = {r1_r, r1_g, r1_b, r2_r, r2_g, r2_b};

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_mask(input int idx);
        case (idx)
            0:       return 32'h0000_0001;
            1:       return 32'h0000_FFFF;
            default: return 32'h00FF_FFFF;
        endcase
    endfunction

    function automatic logic mapped(input logic [15:0] addr);
        return (addr[15:5] == 11'd0) && (addr[4:2] <= 3'd4);
    endfunction

    // Reference model of a write: whole-byte replacement under strobe, then keep only implemented bits
    task automatic model_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        logic [31:0] v;
        idx = int'(addr[4:2]);
        if (mapped(addr) && idx < 4) begin
            v = mreg[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) v[8*b +: 8] = data[8*b +: 8];
            mreg[idx] = v & reg_mask(idx);
        end
    endtask

    task automatic model_reset();
        mreg[0] = 32'h0; mreg[1] = 32'hFF; mreg[2] = 32'h0; mreg[3] = 32'h0;
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, output logic [1:0] resp);
        int t;
        bit aw_done;
        bit w_done;
        @(negedge aclk);
        awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
        aw_done = 0; w_done = 0; t = 0;
        while (!(aw_done && w_done) && t < 50) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(negedge aclk);
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            t++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        t = 0;
        while (!bvalid && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check("wr_bvalid_seen", {31'b0, bvalid}, 32'd1);
        resp = bresp;
        @(negedge aclk);
        model_write(addr, data, strb);
    endtask

    task automatic readReg(input logic [15:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int t;
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1; rready = 1'b1; t = 0;
        while (!arready && t < 50) begin
            @(negedge aclk);
            t++;
        end
        @(negedge aclk);
        arvalid = 1'b0;
        t = 0;
        while (!rvalid && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check("rd_rvalid_seen", {31'b0, rvalid}, 32'd1);
        data = rdata;
        resp = rresp;
        @(negedge aclk);
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] addr);
        logic [31:0] d;
        logic [1:0]  r;
        readReg(addr, d, r);
        if (!mapped(addr)) begin
            check({tag, "_data"}, d, 32'h0);
            check({tag, "_resp"}, {30'b0, r}, 32'd3);
        end else begin
            check({tag, "_resp"}, {30'b0, r}, 32'd0);
            if (addr[4:2] < 3'd4)        check({tag, "_data"}, d, mreg[addr[4:2]]);
            else if (mreg[0][0] == 1'b0) check({tag, "_data"}, d, 32'h0);
            else                         check({tag, "_status"}, d & 32'hFFFF_FF00, 32'h100);
        end
    endtask

    task automatic count_leds(input int n);
        for (int k = 0; k < 6; k++) hi[k] = 0;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 6; k++) hi[k] += int'(leds[5-k]);
            @(negedge aclk);
        end
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [15:0] a;
        logic [23:0] duty1, duty2;
        int          bv_cnt, pre, t;
        bit          busy_ok, prev, found;

        areset = 1'b1;
        awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
        araddr = '0; arvalid = 0; rready = 0;
        model_reset();

        repeat (3) @(negedge aclk);
        check("rst_readys", {29'b0, awready, wready, arready}, 32'd0);
        check("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", {28'b0, bresp, rresp}, 32'd0);
        check("rst_leds", {26'b0, leds}, 32'd0);
        areset = 1'b0;
        #1;
        check("post_rst_readys_low", {29'b0, awready, wready, arready}, 32'd0);
        @(negedge aclk);
        check("post_rst_readys_high", {29'b0, awready, wready, arready}, 32'd7);

        checkOutput("rd_prescale_rst", 16'h0004);
        checkOutput("rd_status_rst", 16'h0010);

        applyStimulus(16'h0008, 32'h0080_0040, 4'hF, resp);
        check("wr_rgb1_resp", {30'b0, resp}, 32'd0);
        checkOutput("rd_rgb1_full", 16'h0008);
        applyStimulus(16'h0008, 32'hFFFF_FFFF, 4'h4, resp);
        checkOutput("rd_rgb1_strb", 16'h0008);
        check("rgb1_strb_expect", mreg[2], 32'h00FF_0040);

        // AW three cycles ahead of W while the response is back-pressured
        @(negedge aclk);
        awaddr = 16'h000C; awvalid = 1'b1; bready = 1'b0;
        @(negedge aclk);
        awvalid = 1'b0;
        repeat (2) @(negedge aclk);
        wdata = 32'hAB12_3456; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        bv_cnt = 0; busy_ok = 1;
        repeat (5) begin
            @(negedge aclk);
            bv_cnt += int'(bvalid);
            if (awready || wready) busy_ok = 0;
        end
        check("split_bvalid_held", bv_cnt, 32'd5);
        check("split_readys_blocked", {31'b0, busy_ok}, 32'd1);
        check("split_bresp", {30'b0, bresp}, 32'd0);
        bready = 1'b1;
        @(negedge aclk);
        check("split_bvalid_drop", {31'b0, bvalid}, 32'd0);
        bv_cnt = 0;
        repeat (4) begin
            @(negedge aclk);
            bv_cnt += int'(bvalid);
        end
        check("split_single_b", bv_cnt, 32'd0);
        model_write(16'h000C, 32'hAB12_3456, 4'hF);
        checkOutput("rd_rgb2_split", 16'h000C);

        // Single green channel at 64/256
        applyStimulus(16'h0004, 32'h0, 4'hF, resp);
        applyStimulus(16'h000C, 32'h0, 4'hF, resp);
        applyStimulus(16'h0008, 32'h0000_4000, 4'hF, resp);
        applyStimulus(16'h0000, 32'h1, 4'hF, resp);
        repeat (3) @(negedge aclk);
        count_leds(256);
        for (int k = 0; k < 6; k++) check($sformatf("pwm_g64_ch%0d", k), hi[k], (k == 1) ? 32'd64 : 32'd0);
        checkOutput("rd_status_en", 16'h0010);

        prev = r1_g; found = 0; t = 0;
        while (!found && t < 600) begin
            @(negedge aclk);
            if (r1_g && !prev) found = 1;
            prev = r1_g;
            t++;
        end
        check("period_start_found", {31'b0, found}, 32'd1);
        fork
            count_leds(256);
            applyStimulus(16'h0008, 32'h0000_C000, 4'h2, resp);
        join
        check("midchange_cur_period", hi[1], 32'd64);
        count_leds(256);
        check("midchange_next_period", hi[1], 32'd192);

        // Random register traffic against the model, PWM disabled first
        applyStimulus(16'h0000, 32'h0, 4'hF, resp);
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) a[15 - $urandom_range(0, 10)] = 1'b1;
            applyStimulus(a, $urandom, 4'($urandom), resp);
            check($sformatf("rand_bresp_%0d", i), {30'b0, resp}, mapped(a) ? 32'd0 : 32'd3);
            a = 16'($urandom_range(0, 7) * 4);
            checkOutput($sformatf("rand_rd_%0d", i), a);
        end

        // Random duties on all six channels with a small random prescale
        applyStimulus(16'h0000, 32'h0, 4'hF, resp);
        duty1 = 24'($urandom); duty2 = 24'($urandom); pre = $urandom_range(0, 2);
        applyStimulus(16'h0004, 32'(pre), 4'hF, resp);
        applyStimulus(16'h0008, {8'h0, duty1}, 4'hF, resp);
        applyStimulus(16'h000C, {8'h0, duty2}, 4'hF, resp);
        applyStimulus(16'h0000, 32'h1, 4'h1, resp);
        repeat (4) @(negedge aclk);
        count_leds(256 * (pre + 1));
        check("rand_pwm_r1", hi[0], 32'(duty1[23:16]) * 32'(pre + 1));
        check("rand_pwm_g1", hi[1], 32'(duty1[15:8]) * 32'(pre + 1));
        check("rand_pwm_b1", hi[2], 32'(duty1[7:0]) * 32'(pre + 1));
        check("rand_pwm_r2", hi[3], 32'(duty2[23:16]) * 32'(pre + 1));
        check("rand_pwm_g2", hi[4], 32'(duty2[15:8]) * 32'(pre + 1));
        check("rand_pwm_b2", hi[5], 32'(duty2[7:0]) * 32'(pre + 1));

        // Decode errors leave the map untouched
        checkOutput("rd_decerr_20", 16'h0020);
        applyStimulus(16'h0014, 32'hFFFF_FFFF, 4'hF, resp);
        check("wr_decerr_14", {30'b0, resp}, 32'd3);
        applyStimulus(16'h0010, 32'hFFFF_FFFF, 4'hF, resp);
        check("wr_status_okay", {30'b0, resp}, 32'd0);
        for (int r = 0; r < 4; r++) checkOutput($sformatf("rd_after_err_%0d", r), 16'(r * 4));

        // Reset while a read response is stalled
        @(negedge aclk);
        araddr = 16'h0008; arvalid = 1'b1; rready = 1'b0;
        @(negedge aclk);
        arvalid = 1'b0;
        @(negedge aclk);
        check("stall_rvalid", {31'b0, rvalid}, 32'd1);
        #2 areset = 1'b1;
        #1;
        check("async_rst_valids", {30'b0, rvalid, bvalid}, 32'd0);
        check("async_rst_readys", {29'b0, awready, wready, arready}, 32'd0);
        check("async_rst_rdata", rdata, 32'd0);
        check("async_rst_leds", {26'b0, leds}, 32'd0);
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("rd_prescale_after_rst", 16'h0004);
        checkOutput("rd_rgb1_after_rst", 16'h0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
